// File: rtl/seq_mult4_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding,
// default operand width and the iteration-counter width helper.
package seq_mult4_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int count_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_mult4_add_nbit.sv
// Purely combinational N-bit adder with carry in and carry out.
module add_nbit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};

endmodule

// File: rtl/seq_mult4.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock,
// registered 2*WIDTH-bit result and a one-cycle done pulse.
module seq_mult4
    import seq_mult4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int CW = count_width(WIDTH);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] p_q;
    logic [2*WIDTH-1:0] p_d;
    logic [2*WIDTH-1:0] product_q;
    logic [CW-1:0]      count_q;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               c_out;

    assign addend = p_q[0] ? a_q : '0;

    add_nbit #(
        .WIDTH(WIDTH)
    ) u_add (
        .a    (p_q[2*WIDTH-1:WIDTH]),
        .b    (addend),
        .c_in (1'b0),
        .sum  (sum),
        .c_out(c_out)
    );

    // The adder carry lands in the MSB, so the accumulator can never overflow.
    assign p_d = {c_out, sum, p_q[WIDTH-1:1]};

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; reset is asynchronous and clears every register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            p_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        p_q     <= {{WIDTH{1'b0}}, b};
                        count_q <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    p_q     <= p_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        product_q <= p_d;
                        state_q   <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign product = product_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_seq_mult4.sv
// Self-checking bench for seq_mult4: cycle-level behavioural model plus
// directed vectors with hand-computed products.
module tb_seq_mult4;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    seq_mult4 #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .product(product),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request keeps the unit busy for WIDTH+1 cycles; the
    // product a*b appears when one busy cycle remains, which is also the done cycle.
    int             m_left;
    logic [2*W-1:0] m_pend;
    logic [2*W-1:0] m_prod;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_pend <= '0;
            m_prod <= '0;
        end else if (m_left == 0) begin
            if (start) begin
                m_left <= W + 1;
                m_pend <= (2*W)'(a) * (2*W)'(b);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) m_prod <= m_pend;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy", 16'(busy), 16'(m_left != 0));
            check("cyc_done", 16'(done), 16'(m_left == 1));
            check("cyc_product", 16'(product), 16'(m_prod));
        end
    end

    task automatic run_op(input string name, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic [2*W-1:0] exp);
        int dones = 0;
        int busys = 0;
        @(negedge clk);
        start = 1'b1;
        a     = ai;
        b     = bi;
        @(negedge clk);
        start = 1'b0;
        if (busy) busys++;
        repeat (8) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busys++;
        end
        check({name, "_product"}, 16'(product), 16'(exp));
        check({name, "_dones"}, 16'(dones), 16'd1);
        check({name, "_busy_cycles"}, 16'(busys), 16'd5);
    endtask

    initial begin
        int dones;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("reset_product", 16'(product), 16'h0);
        check("reset_busy", 16'(busy), 16'h0);
        check("reset_done", 16'(done), 16'h0);
        @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;

        run_op("max", 4'hF, 4'hF, 8'hE1);
        repeat (3) @(negedge clk);
        check("max_hold", 16'(product), 16'h00E1);

        run_op("13x11", 4'd13, 4'd11, 8'h8F);
        run_op("0x9", 4'd0, 4'd9, 8'h00);

        // Start while busy at E2 must be ignored.
        dones = 0;
        @(negedge clk);
        start = 1'b1; a = 4'd3; b = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 4'd15; b = 4'd15;
        @(negedge clk);
        start = 1'b0;
        if (done) dones++;
        repeat (8) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("busy_start_product", 16'(product), 16'h000F);
        check("busy_start_dones", 16'(dones), 16'd1);

        // Operand churn during RUN has no effect.
        dones = 0;
        @(negedge clk);
        start = 1'b1; a = 4'd7; b = 4'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (8) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            @(negedge clk);
            if (done) dones++;
        end
        check("churn_product", 16'(product), 16'h002A);
        check("churn_dones", 16'(dones), 16'd1);

        // Asynchronous reset between edges mid-RUN.
        @(negedge clk);
        start = 1'b1; a = 4'd9; b = 4'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_product", 16'(product), 16'h0);
        check("async_rst_busy", 16'(busy), 16'h0);
        check("async_rst_done", 16'(done), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("post_rst_dones", 16'(dones), 16'd0);
        check("post_rst_product", 16'(product), 16'h0);
        run_op("2x3", 4'd2, 4'd3, 8'h06);

        // Held start: accepted at E0, E6, E12; done after E4, E10, E16.
        dones = 0;
        @(negedge clk);
        start = 1'b1; a = 4'd1; b = 4'd1;
        repeat (18) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("held_start_dones", 16'(dones), 16'd3);
        check("held_start_product", 16'(product), 16'h0001);
        start = 1'b0;
        repeat (8) @(negedge clk);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
